// File: rtl/mips_pkg.sv
// Shared widths, occupancy states and the queue-entry layout for the
// EXE->MEM request queue.
package mips_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEST_W = 5;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  // Entry layout at the default widths; the top rebuilds the same shape from
  // its own parameters so overrides stay consistent.
  typedef struct packed {
    logic                  wb_en;
    logic                  mem_read;
    logic                  mem_write;
    logic [DEF_DEST_W-1:0] dest;
    logic [DEF_ADDR_W-1:0] alu_res;
    logic [DEF_DATA_W-1:0] st_val;
  } q_entry_t;

endpackage

// File: rtl/req_fifo.sv
// Two-entry storage with 1-bit read/write pointers; occupancy is tracked by
// the owner, which only raises push_i/pop_i when legal.
module req_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] head_o
);

  logic [1:0][W-1:0] mem_q;
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;

  always_comb begin
    wptr_d = push_i ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop_i  ? rptr_q + 1'b1 : rptr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      if (push_i) mem_q[wptr_q] <= wdata_i;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign head_o = mem_q[rptr_q];

endmodule

// File: rtl/mem_req_queue.sv
// Decouples EXE from a stalling memory stage: 2-deep request queue, head
// drives the memory request, retired entries land in the WB register.
module mem_req_queue
  import mips_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEST_W = DEF_DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_valid,
  input  logic              exe_wb_en,
  input  logic              exe_mem_read,
  input  logic              exe_mem_write,
  input  logic [DEST_W-1:0] exe_dest,
  input  logic [ADDR_W-1:0] exe_alu_res,
  input  logic [DATA_W-1:0] exe_st_val,
  output logic              exe_freeze,
  output logic              mem_wb_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              wb_valid,
  output logic              wb_wb_en,
  output logic              wb_mem_read,
  output logic [ADDR_W-1:0] wb_alu_res,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DEST_W-1:0] wb_dest,
  output logic [15:0]       stall_cycles
);

  typedef struct packed {
    logic              wb_en;
    logic              mem_read;
    logic              mem_write;
    logic [DEST_W-1:0] dest;
    logic [ADDR_W-1:0] alu_res;
    logic [DATA_W-1:0] st_val;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  q_state_e          state_q, state_d;
  entry_t            push_ent, head;
  logic              push, pop, nonempty, head_mem, stall;

  logic [ADDR_W-1:0] addr_hold_q;
  logic [DATA_W-1:0] data_hold_q;
  logic              wb_valid_q, wb_wb_en_q, wb_mem_read_q;
  logic [ADDR_W-1:0] wb_alu_res_q;
  logic [DATA_W-1:0] wb_read_data_q;
  logic [DEST_W-1:0] wb_dest_q;
  logic [15:0]       stall_q, stall_d;

  always_comb begin
    push_ent           = '0;
    push_ent.wb_en     = exe_wb_en;
    push_ent.mem_read  = exe_mem_read;
    push_ent.mem_write = exe_mem_write;
    push_ent.dest      = exe_dest;
    push_ent.alu_res   = exe_alu_res;
    push_ent.st_val    = exe_st_val;
  end

  req_fifo #(.W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_ent),
    .head_o  (head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= Q_EMPTY;
    else      state_q <= state_d;
  end

  // Freeze comes from registered occupancy only, so mem_ready never reaches
  // the upstream stall path combinationally.
  always_comb begin
    state_d     = state_q;
    nonempty    = (state_q != Q_EMPTY);
    head_mem    = head.mem_read | head.mem_write;
    pop         = nonempty & (~head_mem | mem_ready);
    push        = exe_valid & (state_q != Q_FULL);
    stall       = nonempty & head_mem & ~mem_ready;
    exe_freeze  = (state_q == Q_FULL);
    mem_wb_en   = nonempty & head.wb_en;
    mem_read    = nonempty & head.mem_read;
    mem_write   = nonempty & head.mem_write;
    mem_address = nonempty ? head.alu_res : addr_hold_q;
    mem_data    = nonempty ? head.st_val  : data_hold_q;
    unique case (state_q)
      Q_EMPTY: if (push) state_d = Q_ONE;
      Q_ONE: begin
        if (push && !pop)      state_d = Q_FULL;
        else if (!push && pop) state_d = Q_EMPTY;
      end
      Q_FULL:  if (pop) state_d = Q_ONE;
      default: state_d = Q_EMPTY;
    endcase
  end

  // Last head address/data, presented while the queue is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_hold_q <= '0;
      data_hold_q <= '0;
    end else if (nonempty) begin
      addr_hold_q <= head.alu_res;
      data_hold_q <= head.st_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q     <= 1'b0;
      wb_wb_en_q     <= 1'b0;
      wb_mem_read_q  <= 1'b0;
      wb_alu_res_q   <= '0;
      wb_read_data_q <= '0;
      wb_dest_q      <= '0;
    end else if (pop) begin
      wb_valid_q     <= 1'b1;
      wb_wb_en_q     <= head.wb_en;
      wb_mem_read_q  <= head.mem_read;
      wb_alu_res_q   <= head.alu_res;
      wb_read_data_q <= mem_read_data;
      wb_dest_q      <= head.dest;
    end else begin
      wb_valid_q     <= 1'b0;
      wb_wb_en_q     <= 1'b0;
      wb_mem_read_q  <= 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stall && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign wb_valid     = wb_valid_q;
  assign wb_wb_en     = wb_wb_en_q;
  assign wb_mem_read  = wb_mem_read_q;
  assign wb_alu_res   = wb_alu_res_q;
  assign wb_read_data = wb_read_data_q;
  assign wb_dest      = wb_dest_q;
  assign stall_cycles = stall_q;

endmodule
